// File: rtl/serial_alu_pkg.sv
// Shared encodings for the digit-serial ALU: operation codes, NZCV flag indices, FSM states.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_arith(alu_op_e op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

  // Beat counter needs at least one bit even when a single beat covers the word.
  function automatic int cnt_width(int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/alu_digit.sv
// One DIGIT-wide slice of the ALU, purely combinational; serial_alu chains it over time via its carry register.
module alu_digit
  import serial_alu_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  alu_op_e          op,
  output logic [DIGIT-1:0] y,
  output logic             cout
);

  logic [DIGIT-1:0] b_eff;
  logic [DIGIT:0]   sum;

  always_comb begin
    b_eff = (op == ALU_SUB) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{DIGIT{1'b0}}, cin};
    y     = sum[DIGIT-1:0];
    cout  = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        y    = sum[DIGIT-1:0];
        cout = sum[DIGIT];
      end
      ALU_AND: y = a & b;
      ALU_ORR: y = a | b;
      default: y = sum[DIGIT-1:0];
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Digit-serial ADD/SUB/AND/ORR with NZCV flags; accept edge t -> Done during the cycle after edge t+N.
// Ready is low only while running; a Start seen without Ready is dropped, never queued.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  output logic             Ready,
  input  logic [1:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags,
  output logic             Done
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(N);
  localparam int SH_W  = (N > 1) ? (WIDTH - DIGIT) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N - 1);

  state_e             state_q, state_d;
  alu_op_e            op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [SH_W-1:0]    sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [3:0]         flg_q, flg_d;

  logic [DIGIT-1:0]   dig_y;
  logic               dig_cout;
  logic [WIDTH-1:0]   final_res;
  logic [SH_W-1:0]    sh_next;
  logic               accept;
  logic               last_beat;
  logic               b_msb_eff;

  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .op   (op_q),
    .y    (dig_y),
    .cout (dig_cout)
  );

  // The final digit goes straight into the result, so the shift register only holds the lower N-1 digits.
  generate
    if (N > 1) begin : g_multi
      assign final_res = {dig_y, sh_q};
      assign sh_next   = final_res[WIDTH-1:DIGIT];
    end else begin : g_single
      assign final_res = dig_y;
      assign sh_next   = sh_q;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    res_d     = res_q;
    flg_d     = flg_q;

    Ready     = (state_q != S_RUN);
    Done      = (state_q == S_DONE);
    accept    = Start && Ready;
    last_beat = (state_q == S_RUN) && (cnt_q == LAST_BEAT);
    // At the last beat the low digit of b_q is B's top digit.
    b_msb_eff = (op_q == ALU_SUB) ? ~b_q[DIGIT-1] : b_q[DIGIT-1];

    case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_RUN;
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sh_d    = sh_next;
        carry_d = dig_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_beat) begin
          state_d       = S_DONE;
          res_d         = final_res;
          flg_d[FLAG_N] = final_res[WIDTH-1];
          flg_d[FLAG_Z] = (final_res == '0);
          flg_d[FLAG_C] = is_arith(op_q) ? dig_cout : 1'b0;
          flg_d[FLAG_V] = is_arith(op_q) &&
                          (a_q[DIGIT-1] == b_msb_eff) && (dig_y[DIGIT-1] != a_q[DIGIT-1]);
        end
      end
      S_DONE: begin
        state_d = Start ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      op_d    = alu_op_e'(ALUControl);
      a_d     = SrcA;
      b_d     = SrcB;
      cnt_d   = '0;
      carry_d = (alu_op_e'(ALUControl) == ALU_SUB);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= ALU_ADD;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign ALUResult = res_q;
  assign ALUFlags  = flg_q;

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu: stimulus pushes expected result/flags/done-cycle, a monitor pops on Done.
module tb_serial_alu;

  localparam int WIDTH = 32;
  localparam int DIGIT = 8;
  localparam int N     = WIDTH / DIGIT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  ALUControl = 2'b00;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        Ready;
  logic [31:0] ALUResult;
  logic [3:0]  ALUFlags;
  logic        Done;

  serial_alu #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .Ready      (Ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUResult  (ALUResult),
    .ALUFlags   (ALUFlags),
    .Done       (Done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_res = '0;
  logic [3:0]  last_flg = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: whole-word arithmetic straight from the NZCV definitions.
  function automatic logic [35:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        c;
    logic        v;
    case (op)
      2'b00:   s = {1'b0, a} + {1'b0, b};
      2'b01:   s = {1'b0, a} + {1'b0, ~b} + 33'd1;
      2'b10:   s = {1'b0, a & b};
      default: s = {1'b0, a | b};
    endcase
    r = s[31:0];
    c = op[1] ? 1'b0 : s[32];
    case (op)
      2'b00:   v = (a[31] == b[31]) && (r[31] != a[31]);
      2'b01:   v = (a[31] != b[31]) && (r[31] != a[31]);
      default: v = 1'b0;
    endcase
    return {r, r[31], (r == 32'd0), c, v};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      last_res = '0;
      last_flg = '0;
    end else if (Done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: Done=1 with no operation outstanding (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", 64'(ALUResult), 64'(mon_e.res));
        check("flags", 64'(ALUFlags), 64'(mon_e.flg));
        check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        last_res = mon_e.res;
        last_flg = mon_e.flg;
      end
    end else begin
      check("hold_outputs", 64'({ALUResult, ALUFlags}), 64'({last_res, last_flg}));
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic [3:0] ef, input bit junk, output int acc);
    int guard = 0;
    while (Ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (Ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_timeout: Ready=%b after %0d cycles, required 1", Ready, guard);
    end
    Start      = 1'b1;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    acc        = cyc + 1;
    exp_q.push_back('{er, ef, acc + N});
    @(negedge clk);
    Start      = junk;
    ALUControl = 2'($urandom);
    SrcA       = 32'hFFFF_FFFF;
    SrcB       = $urandom;
  endtask

  task automatic send_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit junk, output int acc);
    logic [35:0] m;
    m = model(op, a, b);
    send(op, a, b, m[35:4], m[3:0], junk, acc);
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d ops outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, dummy;

    // 1. reset state and idle quiet
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(Ready), 64'(1));
    check("rst_done", 64'(Done), 64'(0));
    check("rst_result", 64'(ALUResult), 64'(0));
    check("rst_flags", 64'(ALUFlags), 64'(0));
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_no_done", 64'(Done), 64'(0));
      check("idle_ready", 64'(Ready), 64'(1));
    end

    // 2. basic ADD/SUB
    send(2'b00, 32'd1, 32'd0, 32'd1, 4'b0000, 1'b0, dummy);
    drain();
    send(2'b01, 32'd1, 32'd1, 32'd0, 4'b0110, 1'b0, dummy);

    // 3. overflow / carry / borrow edges
    send(2'b00, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1001, 1'b0, dummy);
    send(2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0110, 1'b0, dummy);
    send(2'b01, 32'd0, 32'd1, 32'hFFFF_FFFF, 4'b1000, 1'b0, dummy);

    // 4. logic ops
    send(2'b10, 32'd1, 32'd1, 32'd1, 4'b0000, 1'b0, dummy);
    send(2'b11, 32'd0, 32'd1, 32'd1, 4'b0000, 1'b0, dummy);
    send(2'b10, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'd0, 4'b0100, 1'b0, dummy);
    drain();

    // 5. Start held high during RUN is ignored; held in DONE gives back-to-back accept
    send(2'b00, 32'd5, 32'd3, 32'd8, 4'b0000, 1'b1, acc1);
    send(2'b01, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b1000, 1'b0, acc2);
    check("b2b_accept_edge", 64'(acc2), 64'(acc1 + N + 1));
    drain();

    // randomized ops, gaps and back-to-back runs against the reference model
    for (int i = 0; i < 300; i++) begin
      send_model(2'($urandom), pick(), pick(), 1'($urandom), dummy);
      if ($urandom % 3 == 0) begin
        Start = 1'b0;
        repeat ($urandom % 3) @(negedge clk);
      end
    end
    Start = 1'b0;
    drain();

    // 6. asynchronous reset during beat 2 discards the op
    send(2'b00, 32'd2, 32'd5, 32'd7, 4'b0000, 1'b0, dummy);
    drain();
    send(2'b00, 32'd9, 32'd9, 32'd18, 4'b0000, 1'b0, dummy);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_result", 64'(ALUResult), 64'(0));
    check("arst_flags", 64'(ALUFlags), 64'(0));
    check("arst_done", 64'(Done), 64'(0));
    check("arst_ready", 64'(Ready), 64'(1));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    send(2'b00, 32'd2, 32'd2, 32'd4, 4'b0000, 1'b0, dummy);
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
